// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port RAM with a
// registered read path.
//
// M0 (CPU) and M1 (loader/debug) compete for the RAM. A conflict goes round
// robin: the port opposite the last owner wins from IDLE, and the current
// owner keeps the RAM for at most MAX_BURST consecutive grants while the other
// port is waiting. A lone requester is granted every cycle.
//
// Optional feature: define ARB_FIXED_PRIO_EN to make M0 win every conflict.
// In that build MAX_BURST and last_owner do not affect arbitration, and M1 may
// starve.
//
// Read data returns one cycle after the grant. rvalid is registered from the
// grant. rdata is a qualified view of RAM_RDATA and reads as zero when rvalid
// is low.
module mem_arbiter #(
  parameter int MAX_BURST = 4  // legal range 1..15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        M0_REQ,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  input  logic [4:0]  M0_WMASK,
  input  logic        M1_REQ,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  input  logic [4:0]  M1_WMASK,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [4:0]  ram_wmask,
  input  logic [31:0] RAM_RDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t     state, state_next;
  logic [3:0] burst_cnt, burst_next, burst_inc;
  logic       last_owner, last_owner_next;

  // Burst counter value for a repeat grant; it saturates at the burst limit.
  assign burst_inc = (burst_cnt < BURST_MAX) ? burst_cnt + 4'd1 : burst_cnt;

  // Winner selection, RAM mux, and next arbitration state.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    m0_gnt          = 1'b0;
    m1_gnt          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_wmask       = '0;
    state_next      = IDLE;
    burst_next      = '0;
    last_owner_next = last_owner;

    // Grants are gated by RESET_N so that nothing reaches the RAM while reset is asserted.
    if (RESET_N) begin
      if (M0_REQ && M1_REQ) begin
`ifdef ARB_FIXED_PRIO_EN
        m0_gnt = 1'b1;
`else
        unique case (state)
          OWN0: if (burst_cnt < BURST_MAX) m0_gnt = 1'b1; else m1_gnt = 1'b1;
          OWN1: if (burst_cnt < BURST_MAX) m1_gnt = 1'b1; else m0_gnt = 1'b1;
          default: if (last_owner) m0_gnt = 1'b1; else m1_gnt = 1'b1;
        endcase
`endif
      end else begin
        m0_gnt = M0_REQ;
        m1_gnt = M1_REQ;
      end
    end

    if (m0_gnt) begin
      ram_addr        = M0_ADDR;
      ram_wdata       = M0_WDATA;
      ram_wmask       = M0_WMASK;
      state_next      = OWN0;
      last_owner_next = 1'b0;
      burst_next      = (state == OWN0) ? burst_inc : 4'd1;
    end else if (m1_gnt) begin
      ram_addr        = M1_ADDR;
      ram_wdata       = M1_WDATA;
      ram_wmask       = M1_WMASK;
      state_next      = OWN1;
      last_owner_next = 1'b1;
      burst_next      = (state == OWN1) ? burst_inc : 4'd1;
    end
  end

  // Arbitration state register; reset makes M0 the winner of the first tie.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge values, which matches the hardware.
      state      <= state_next;
      burst_cnt  <= burst_next;
      last_owner <= last_owner_next;
    end
  end

  // Read-return tracking: a granted read produces rvalid on the following cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt && !M0_WMASK[0];
      m1_rvalid <= m1_gnt && !M1_WMASK[0];
    end
  end

  assign m0_rdata = m0_rvalid ? RAM_RDATA : '0;
  assign m1_rdata = m1_rvalid ? RAM_RDATA : '0;

endmodule
